// File: rtl/vdma_seq_pkg.sv
// vdma_seq_pkg -- types shared by the VDMA read- and write-side frame sequencers.
//   seq_state_t : sequencer state encoding
//   cnt16_t     : 16-bit line/pixel/delay count
//   dly_ld()    : turns an N-cycle wait into the load value for seq_delay_cnt
package vdma_seq_pkg;

  typedef logic [15:0] cnt16_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBLANK,
    S_REQ,
    S_WAIT_LINE,
    S_ACTIVE,
    S_HBLANK
  } seq_state_t;

  // seq_delay_cnt reports done once it has counted down to zero, so an
  // N-cycle wait is loaded with N-1.
  function automatic cnt16_t dly_ld(input int unsigned n);
    return cnt16_t'(n - 1);
  endfunction

endpackage

// File: rtl/seq_delay_cnt.sv
// seq_delay_cnt -- loadable down-counter used for the VSYNC, VBLANK and
// HBLANK waits of the frame sequencer.
//   aclk, aresetn : clock, async active-low reset
//   load          : load load_val this cycle (takes priority over counting)
//   load_val      : value to load; a wait of N cycles loads N-1
//   done          : count is zero (the current cycle is the last of the wait)
module seq_delay_cnt
  import vdma_seq_pkg::*;
(
  input  logic   aclk,
  input  logic   aresetn,
  input  logic   load,
  input  cnt16_t load_val,
  output logic   done
);

  cnt16_t cnt;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)         cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - 16'd1;
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/stream_out_frame_seq.sv
// stream_out_frame_seq -- frame/line timing sequencer for the AXI-stream
// output port. Produces vsync/hsync/de/first_vld_byte, one line_req per line,
// and line/frame completion pulses. Pixels advance only on accepted beats
// (out_de && axi_tready), matching the port's rd_en.
//
// Ports:
//   aclk, aresetn        clock, async active-low reset
//   enable               run frames while high (frame in flight always finishes)
//   vactive, hactive     lines/frame and pixels/line, latched at frame start
//   line_rdy             line buffer holds a full line
//   axi_tready           downstream ready
//   line_req             1-cycle line fetch request
//   out_vsync/out_hsync  sync to the port
//   out_de               pixel valid to the port
//   first_vld_byte       first pixel of the frame is on the port
//   line_done/frame_done 1-cycle pulse after the last accepted beat
//   busy                 sequencer not idle
//   cfg_err              sticky: frame start attempted with a zero dimension
//   stall_cnt            cycles with out_de && !axi_tready
//
// Build option: define STREAM_SEQ_STALL_CNT_EN to compile the saturating
// stall counter; otherwise stall_cnt is tied to zero.
module stream_out_frame_seq
  import vdma_seq_pkg::*;
#(
  parameter int unsigned VS_WIDTH = 4,
  parameter int unsigned VBLANK   = 8,
  parameter int unsigned HBLANK   = 4
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        enable,
  input  logic [15:0] vactive,
  input  logic [15:0] hactive,
  input  logic        line_rdy,
  input  logic        axi_tready,
  output logic        line_req,
  output logic        out_vsync,
  output logic        out_hsync,
  output logic        out_de,
  output logic        first_vld_byte,
  output logic        line_done,
  output logic        frame_done,
  output logic        busy,
  output logic        cfg_err,
  output logic [31:0] stall_cnt
);

  localparam cnt16_t VS_LD = dly_ld(VS_WIDTH);
  localparam cnt16_t VB_LD = dly_ld(VBLANK);
  localparam cnt16_t HB_LD = dly_ld(HBLANK);

  seq_state_t state, nxt_state;
  cnt16_t     line_cnt, nxt_line;
  cnt16_t     pix_cnt,  nxt_pix;
  cnt16_t     vact_q,   nxt_vact;
  cnt16_t     hact_q,   nxt_hact;

  logic   dly_load, dly_done;
  cnt16_t dly_val;
  logic   set_err, nxt_ld, nxt_fd;
  logic   accept;

  seq_delay_cnt u_dly (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .load     (dly_load),
    .load_val (dly_val),
    .done     (dly_done)
  );

  // out_de is a registered copy of (state == S_ACTIVE), so this is exactly
  // the beat the port sees as rd_en.
  assign accept = out_de && axi_tready;

  always_comb begin
    nxt_state = state;
    nxt_line  = line_cnt;
    nxt_pix   = pix_cnt;
    nxt_vact  = vact_q;
    nxt_hact  = hact_q;
    dly_load  = 1'b0;
    dly_val   = '0;
    set_err   = 1'b0;
    nxt_ld    = 1'b0;
    nxt_fd    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (enable) begin
          nxt_vact = vactive;
          nxt_hact = hactive;
          if (vactive == '0 || hactive == '0) begin
            set_err = 1'b1;
          end else begin
            nxt_state = S_VSYNC;
            nxt_line  = '0;
            dly_load  = 1'b1;
            dly_val   = VS_LD;
          end
        end
      end
      S_VSYNC: begin
        if (dly_done) begin
          nxt_state = S_VBLANK;
          dly_load  = 1'b1;
          dly_val   = VB_LD;
        end
      end
      S_VBLANK: if (dly_done) nxt_state = S_REQ;
      S_REQ:    nxt_state = S_WAIT_LINE;
      S_WAIT_LINE: begin
        if (line_rdy) begin
          nxt_state = S_ACTIVE;
          nxt_pix   = '0;
        end
      end
      S_ACTIVE: begin
        // line_rdy is deliberately ignored here: the buffer owns the whole line.
        if (accept) begin
          if (pix_cnt == hact_q - 16'd1) begin
            nxt_ld   = 1'b1;
            nxt_pix  = '0;
            nxt_line = line_cnt + 16'd1;
            if (line_cnt == vact_q - 16'd1) begin
              nxt_fd    = 1'b1;
              nxt_state = S_IDLE;
            end else begin
              nxt_state = S_HBLANK;
              dly_load  = 1'b1;
              dly_val   = HB_LD;
            end
          end else begin
            nxt_pix = pix_cnt + 16'd1;
          end
        end
      end
      S_HBLANK: if (dly_done) nxt_state = S_REQ;
      default:  nxt_state = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state
  // they describe while still coming straight from flops.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state          <= S_IDLE;
      line_cnt       <= '0;
      pix_cnt        <= '0;
      vact_q         <= '0;
      hact_q         <= '0;
      line_req       <= 1'b0;
      out_vsync      <= 1'b0;
      out_hsync      <= 1'b0;
      out_de         <= 1'b0;
      first_vld_byte <= 1'b0;
      line_done      <= 1'b0;
      frame_done     <= 1'b0;
      busy           <= 1'b0;
      cfg_err        <= 1'b0;
    end else begin
      state          <= nxt_state;
      line_cnt       <= nxt_line;
      pix_cnt        <= nxt_pix;
      vact_q         <= nxt_vact;
      hact_q         <= nxt_hact;
      line_req       <= (nxt_state == S_REQ);
      out_vsync      <= (nxt_state == S_VSYNC);
      out_hsync      <= (nxt_state == S_HBLANK);
      out_de         <= (nxt_state == S_ACTIVE);
      first_vld_byte <= (nxt_state == S_ACTIVE) && (nxt_line == '0) && (nxt_pix == '0);
      line_done      <= nxt_ld;
      frame_done     <= nxt_fd;
      busy           <= (nxt_state != S_IDLE);
      cfg_err        <= cfg_err | set_err;
    end
  end

`ifdef STREAM_SEQ_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)
      stall_q <= '0;
    else if (out_de && !axi_tready && stall_q != 32'hFFFF_FFFF)
      stall_q <= stall_q + 32'd1;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_stream_out_frame_seq.sv
module tb_stream_out_frame_seq;

  localparam int VS_W = 4;
  localparam int VB   = 8;
  localparam int HB   = 4;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] vactive = '0, hactive = '0;
  logic        line_rdy = 1'b0, axi_tready = 1'b0;
  logic        line_req, out_vsync, out_hsync, out_de, first_vld_byte;
  logic        line_done, frame_done, busy, cfg_err;
  logic [31:0] stall_cnt;

  stream_out_frame_seq #(.VS_WIDTH(VS_W), .VBLANK(VB), .HBLANK(HB)) dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable), .vactive(vactive),
    .hactive(hactive), .line_rdy(line_rdy), .axi_tready(axi_tready),
    .line_req(line_req), .out_vsync(out_vsync), .out_hsync(out_hsync),
    .out_de(out_de), .first_vld_byte(first_vld_byte), .line_done(line_done),
    .frame_done(frame_done), .busy(busy), .cfg_err(cfg_err), .stall_cnt(stall_cnt)
  );

  always #5 aclk = ~aclk;

  int vectors = 0, miscompares = 0;
  bit rnd_tready = 0, rnd_lrdy = 0;

  // Reference model: a frame is m_vact lines of m_hact accepted beats; the
  // monitor observes the port and tallies events against those rules.
  int m_hact = 1, m_vact = 1;
  int beats_line, lines_seen, beats_frame;
  bit pend_ld, pend_fd;
  int n_vs, n_hs, n_de, n_acc, n_req, n_ld, n_fd, n_stall;
  int bad_pulse, bad_fvb, bad_ovl;

  task automatic mon_clear_frame();
    n_vs = 0; n_hs = 0; n_de = 0; n_acc = 0; n_req = 0; n_ld = 0; n_fd = 0;
    bad_pulse = 0; bad_fvb = 0; bad_ovl = 0;
  endtask

  task automatic mon_clear_all();
    mon_clear_frame();
    beats_line = 0; lines_seen = 0; beats_frame = 0;
    pend_ld = 0; pend_fd = 0; n_stall = 0;
  endtask

  initial begin
    mon_clear_all();
    forever begin
      @(negedge aclk);
      if (aresetn) begin
        if (out_vsync) n_vs++;
        if (out_hsync) n_hs++;
        if (out_de)    n_de++;
        if (line_req)  n_req++;
        if (line_done) n_ld++;
        if (frame_done) n_fd++;
        if (line_done !== pend_ld || frame_done !== pend_fd) bad_pulse++;
        if ((line_done || frame_done) && out_de) bad_pulse++;
        if (first_vld_byte !== (out_de && beats_frame == 0)) bad_fvb++;
        if (out_de && (out_vsync || out_hsync)) bad_ovl++;
        pend_ld = 0; pend_fd = 0;
        if (out_de && !axi_tready) n_stall++;
        if (out_de && axi_tready) begin
          n_acc++; beats_frame++; beats_line++;
          if (beats_line == m_hact) begin
            beats_line = 0; pend_ld = 1; lines_seen++;
            if (lines_seen == m_vact) begin
              pend_fd = 1; lines_seen = 0; beats_frame = 0;
            end
          end
        end
      end
    end
  end

  function automatic int exp_stall();
`ifdef STREAM_SEQ_STALL_CNT_EN
    return n_stall;
`else
    return 0;
`endif
  endfunction

  task automatic tick();
    @(posedge aclk); #1;
    if (rnd_tready) axi_tready = ($urandom_range(0, 3) != 0);
    if (rnd_lrdy)   line_rdy   = ($urandom_range(0, 2) != 0);
  endtask

  task automatic do_reset();
    aresetn = 0; enable = 0; vactive = '0; hactive = '0;
    line_rdy = 0; axi_tready = 0; rnd_tready = 0; rnd_lrdy = 0;
    repeat (3) @(posedge aclk);
    #1 aresetn = 1;
    mon_clear_all();
  endtask

  task automatic wait_fd(input int lim);
    int t = 0;
    while (n_fd == 0 && t < lim) begin tick(); t++; end
    repeat (3) tick();
  endtask

  task automatic wait_de(input int lim);
    int t = 0;
    while (!out_de && t < lim) begin tick(); t++; end
  endtask

  task automatic test_reset();
    aresetn = 0; #3;
    vectors++; if ({line_req, out_vsync, out_hsync, out_de, first_vld_byte, line_done, frame_done, busy, cfg_err} !== 9'b0)
      begin miscompares++; $display("FAIL reset_outs got %b want 0", {line_req, out_vsync, out_hsync, out_de, first_vld_byte, line_done, frame_done, busy, cfg_err}); end
    vectors++; if (stall_cnt !== 32'd0) begin miscompares++; $display("FAIL reset_stall got %0d want 0", stall_cnt); end
    do_reset();
    repeat (5) tick();
    vectors++; if (busy !== 1'b0 || n_vs != 0) begin miscompares++; $display("FAIL reset_idle busy=%b vs=%0d want 0/0", busy, n_vs); end
  endtask

  task automatic test_basic();
    int n;
    do_reset();
    m_vact = 2; m_hact = 4; vactive = 16'd2; hactive = 16'd4;
    line_rdy = 1; axi_tready = 1; enable = 1;
    tick(); n = 1;
    vectors++; if (out_vsync !== 1'b1) begin miscompares++; $display("FAIL basic_vsync_next got %b want 1", out_vsync); end
    while (!out_de && n < 100) begin tick(); n++; end
    vectors++; if (n != 1 + VS_W + VB + 2) begin miscompares++; $display("FAIL basic_first_de got %0d want %0d", n, 1 + VS_W + VB + 2); end
    vectors++; if (first_vld_byte !== 1'b1) begin miscompares++; $display("FAIL basic_fvb got %b want 1", first_vld_byte); end
    enable = 0;
    wait_fd(500);
    repeat (10) tick();
    vectors++; if (n_req != 2) begin miscompares++; $display("FAIL basic_req got %0d want 2", n_req); end
    vectors++; if (n_de != 8) begin miscompares++; $display("FAIL basic_de got %0d want 8", n_de); end
    vectors++; if (n_ld != 2 || n_fd != 1) begin miscompares++; $display("FAIL basic_done ld=%0d fd=%0d want 2/1", n_ld, n_fd); end
    vectors++; if (n_vs != VS_W || n_hs != HB) begin miscompares++; $display("FAIL basic_sync vs=%0d hs=%0d want %0d/%0d", n_vs, n_hs, VS_W, HB); end
    vectors++; if (bad_pulse + bad_fvb + bad_ovl != 0) begin miscompares++; $display("FAIL basic_rules got %0d/%0d/%0d want 0", bad_pulse, bad_fvb, bad_ovl); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_idle busy got %b want 0", busy); end
  endtask

  task automatic test_stall();
    do_reset();
    m_vact = 1; m_hact = 4; vactive = 16'd1; hactive = 16'd4;
    line_rdy = 1; axi_tready = 1; enable = 1;
    tick(); enable = 0;
    wait_de(100);
    tick(); tick();
    axi_tready = 0;
    repeat (3) tick();
    axi_tready = 1;
    wait_fd(100);
    vectors++; if (n_de != 7) begin miscompares++; $display("FAIL stall_de got %0d want 7", n_de); end
    vectors++; if (n_stall != 3) begin miscompares++; $display("FAIL stall_obs got %0d want 3", n_stall); end
    vectors++; if (n_ld != 1 || n_fd != 1) begin miscompares++; $display("FAIL stall_done ld=%0d fd=%0d want 1/1", n_ld, n_fd); end
    vectors++; if (stall_cnt !== 32'(exp_stall())) begin miscompares++; $display("FAIL stall_cnt got %0d want %0d", stall_cnt, exp_stall()); end
    vectors++; if (bad_pulse + bad_fvb != 0) begin miscompares++; $display("FAIL stall_rules got %0d/%0d want 0", bad_pulse, bad_fvb); end
  endtask

  task automatic test_wait_line();
    int t = 0, de_seen = 0;
    do_reset();
    m_vact = 1; m_hact = 2; vactive = 16'd1; hactive = 16'd2;
    line_rdy = 0; axi_tready = 1; enable = 1;
    tick(); enable = 0;
    while (!line_req && t < 100) begin tick(); t++; end
    vectors++; if (line_req !== 1'b1) begin miscompares++; $display("FAIL wait_req got %b want 1", line_req); end
    for (int i = 0; i < 10; i++) begin tick(); if (out_de) de_seen++; end
    vectors++; if (de_seen != 0) begin miscompares++; $display("FAIL wait_de_low got %0d want 0", de_seen); end
    line_rdy = 1;
    tick();
    vectors++; if (out_de !== 1'b1) begin miscompares++; $display("FAIL wait_de_rise got %b want 1", out_de); end
    wait_fd(100);
    vectors++; if (n_ld != 1 || n_acc != 2) begin miscompares++; $display("FAIL wait_done ld=%0d acc=%0d want 1/2", n_ld, n_acc); end
  endtask

  task automatic test_cfg_err();
    do_reset();
    vactive = 16'd0; hactive = 16'd5; line_rdy = 1; axi_tready = 1; enable = 1;
    repeat (5) tick();
    vectors++; if (cfg_err !== 1'b1) begin miscompares++; $display("FAIL cfg_set got %b want 1", cfg_err); end
    vectors++; if (busy !== 1'b0 || n_vs != 0) begin miscompares++; $display("FAIL cfg_idle busy=%b vs=%0d want 0/0", busy, n_vs); end
    m_vact = 1; m_hact = 5; vactive = 16'd1;
    tick();
    vectors++; if (out_vsync !== 1'b1) begin miscompares++; $display("FAIL cfg_restart got %b want 1", out_vsync); end
    enable = 0;
    wait_fd(200);
    vectors++; if (cfg_err !== 1'b1) begin miscompares++; $display("FAIL cfg_sticky got %b want 1", cfg_err); end
    vectors++; if (n_fd != 1 || n_acc != 5) begin miscompares++; $display("FAIL cfg_frame fd=%0d acc=%0d want 1/5", n_fd, n_acc); end
  endtask

  task automatic test_enable_drop();
    int h;
    do_reset();
    h = $urandom_range(1, 5);
    m_vact = 3; m_hact = h; vactive = 16'd3; hactive = 16'(h);
    line_rdy = 1; axi_tready = 1; rnd_tready = 1; enable = 1;
    wait_de(100);
    enable = 0;
    wait_fd(1000);
    repeat (30) tick();
    vectors++; if (n_ld != 3 || n_fd != 1) begin miscompares++; $display("FAIL endrop_done ld=%0d fd=%0d want 3/1", n_ld, n_fd); end
    vectors++; if (n_acc != 3 * h) begin miscompares++; $display("FAIL endrop_acc got %0d want %0d", n_acc, 3 * h); end
    vectors++; if (n_vs != VS_W || busy !== 1'b0) begin miscompares++; $display("FAIL endrop_idle vs=%0d busy=%b want %0d/0", n_vs, busy, VS_W); end
    vectors++; if (bad_pulse + bad_fvb + bad_ovl != 0) begin miscompares++; $display("FAIL endrop_rules got %0d/%0d/%0d want 0", bad_pulse, bad_fvb, bad_ovl); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    vactive = 16'd0; hactive = 16'd3; line_rdy = 1; axi_tready = 0; enable = 1;
    tick();
    vectors++; if (cfg_err !== 1'b1) begin miscompares++; $display("FAIL rmid_err_set got %b want 1", cfg_err); end
    vactive = 16'd2; m_vact = 2; m_hact = 3;
    tick();
    wait_de(100);
    repeat (4) tick();
    #2 aresetn = 0; #1;
    vectors++; if (out_de !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL rmid_outs de=%b busy=%b want 0/0", out_de, busy); end
    vectors++; if (stall_cnt !== 32'd0 || cfg_err !== 1'b0) begin miscompares++; $display("FAIL rmid_clr stall=%0d err=%b want 0/0", stall_cnt, cfg_err); end
    @(posedge aclk); #1 aresetn = 1;
    mon_clear_all();
    axi_tready = 1;
    tick();
    vectors++; if (out_vsync !== 1'b1) begin miscompares++; $display("FAIL rmid_fresh got %b want 1", out_vsync); end
    enable = 0;
    wait_fd(300);
    vectors++; if (n_fd != 1 || n_acc != 6) begin miscompares++; $display("FAIL rmid_frame fd=%0d acc=%0d want 1/6", n_fd, n_acc); end
  endtask

  task automatic test_random();
    int v, h;
    do_reset();
    rnd_tready = 1; rnd_lrdy = 1;
    for (int f = 0; f < 6; f++) begin
      v = $urandom_range(1, 4); h = $urandom_range(1, 6);
      m_vact = v; m_hact = h; vactive = 16'(v); hactive = 16'(h);
      mon_clear_frame();
      enable = 1;
      tick();
      // new dimensions mid-frame must not disturb the frame in flight
      vactive = 16'($urandom); hactive = 16'($urandom);
      tick();
      enable = 0;
      wait_fd(3000);
      vectors++; if (n_acc != v * h) begin miscompares++; $display("FAIL rnd%0d_acc got %0d want %0d", f, n_acc, v * h); end
      vectors++; if (n_ld != v || n_req != v) begin miscompares++; $display("FAIL rnd%0d_lines ld=%0d req=%0d want %0d", f, n_ld, n_req, v); end
      vectors++; if (n_fd != 1) begin miscompares++; $display("FAIL rnd%0d_fd got %0d want 1", f, n_fd); end
      vectors++; if (n_hs != (v - 1) * HB || n_vs != VS_W) begin miscompares++; $display("FAIL rnd%0d_sync hs=%0d vs=%0d want %0d/%0d", f, n_hs, n_vs, (v - 1) * HB, VS_W); end
      vectors++; if (bad_pulse + bad_fvb + bad_ovl != 0) begin miscompares++; $display("FAIL rnd%0d_rules got %0d/%0d/%0d want 0", f, bad_pulse, bad_fvb, bad_ovl); end
      vectors++; if (stall_cnt !== 32'(exp_stall())) begin miscompares++; $display("FAIL rnd%0d_stall got %0d want %0d", f, stall_cnt, exp_stall()); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_wait_line();
    test_cfg_err();
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
